// File: rtl/board_supervisor_if.sv
// Board supervisor signal bundle: operator/radio inputs in, sequencer state and status out.
// The master side drives the inputs (board top level); the slave side is the supervisor.
interface board_supervisor_if #(
   parameter int TS_WIDTH = 24
);
   logic                tick;
   logic                btn;
   logic                motor_req;
   logic                throttle_low;
   logic                link_ok;
   logic [1:0]          board_state;
   logic                running;
   logic                motor_en;
   logic [TS_WIDTH-1:0] timestamp;
   logic                fault;

   modport master (
      output tick, btn, motor_req, throttle_low, link_ok,
      input  board_state, running, motor_en, timestamp, fault
   );

   modport slave (
      input  tick, btn, motor_req, throttle_low, link_ok,
      output board_state, running, motor_en, timestamp, fault
   );
endinterface

// File: rtl/board_supervisor.sv
// Board sequencer IDLE->STARTUP->RUNNING->SHUTDOWN with motor arming interlock and flight timestamp.
// Define BOARD_SUPERVISOR_LINK_WATCHDOG_EN to add the radio-link watchdog and sticky fault flag.
module board_supervisor #(
   parameter int TS_WIDTH       = 24,
   parameter int STARTUP_TICKS  = 16,
   parameter int SHUTDOWN_TICKS = 16,
   parameter int LINK_TIMEOUT   = 100,
   parameter int CNT_WIDTH      = 16
) (
   input  logic               clk,
   input  logic               rst,
   board_supervisor_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STARTUP  = 2'd1,
      RUNNING  = 2'd2,
      SHUTDOWN = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] STARTUP_LAST  = CNT_WIDTH'(STARTUP_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] SHUTDOWN_LAST = CNT_WIDTH'(SHUTDOWN_TICKS - 1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 motor_en_q, motor_en_d;
   logic [TS_WIDTH-1:0]  ts_q, ts_d;
   logic                 btn_q, btn_prev_q;
   logic                 motor_req_q, motor_req_prev_q;
   logic                 btn_edge, motor_edge;
   logic                 wd_trip;

   // Edge pipelines reset high so a level held through reset never looks like a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q            <= 1'b1;
         btn_prev_q       <= 1'b1;
         motor_req_q      <= 1'b1;
         motor_req_prev_q <= 1'b1;
      end else begin
         btn_q            <= bus.btn;
         btn_prev_q       <= btn_q;
         motor_req_q      <= bus.motor_req;
         motor_req_prev_q <= motor_req_q;
      end
   end

   assign btn_edge   = btn_q & ~btn_prev_q;
   assign motor_edge = motor_req_q & ~motor_req_prev_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      motor_en_d = 1'b0;
      ts_d       = '0;
      case (state_q)
         IDLE: begin
            if (btn_edge) begin
               state_d = STARTUP;
               cnt_d   = '0;
            end
         end
         STARTUP: begin
            // A press aborts even when the completing tick arrives in the same cycle.
            if (btn_edge) begin
               state_d = SHUTDOWN;
               cnt_d   = '0;
            end else if (bus.tick) begin
               if (cnt_q == STARTUP_LAST) begin
                  state_d = RUNNING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RUNNING: begin
            motor_en_d = motor_en_q;
            if (motor_edge) begin
               if (motor_en_q)
                  motor_en_d = 1'b0;
               else if (bus.throttle_low)
                  motor_en_d = 1'b1;
            end
            ts_d = ts_q;
            if (bus.tick && (ts_q != '1))
               ts_d = ts_q + 1'b1;
            if (btn_edge || wd_trip) begin
               state_d    = SHUTDOWN;
               cnt_d      = '0;
               motor_en_d = 1'b0;
               ts_d       = '0;
            end
         end
         SHUTDOWN: begin
            if (bus.tick) begin
               if (cnt_q == SHUTDOWN_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         motor_en_q <= 1'b0;
         ts_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         motor_en_q <= motor_en_d;
         ts_q       <= ts_d;
      end
   end

`ifdef BOARD_SUPERVISOR_LINK_WATCHDOG_EN
   logic [CNT_WIDTH-1:0] wd_q, wd_d;
   logic                 fault_q, fault_d;

   localparam logic [CNT_WIDTH-1:0] LINK_LAST = CNT_WIDTH'(LINK_TIMEOUT - 1);

   // A valid frame beats a coincident tick; the counter only runs while flying.
   always_comb begin
      wd_d    = '0;
      wd_trip = 1'b0;
      if (state_q == RUNNING) begin
         wd_d = wd_q;
         if (bus.link_ok) begin
            wd_d = '0;
         end else if (bus.tick) begin
            if (wd_q == LINK_LAST) begin
               wd_trip = 1'b1;
               wd_d    = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      fault_d = fault_q;
      if ((state_q == IDLE) && btn_edge)
         fault_d = 1'b0;
      else if (wd_trip)
         fault_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         fault_q <= fault_d;
      end
   end

   assign bus.fault = fault_q;
`else
   assign wd_trip   = 1'b0;
   assign bus.fault = 1'b0;
`endif

   assign bus.board_state = state_q;
   assign bus.running     = (state_q == RUNNING);
   assign bus.motor_en    = motor_en_q;
   assign bus.timestamp   = ts_q;
endmodule

// File: tb/tb_board_supervisor.sv
// Scoreboard bench for board_supervisor: directed scenarios then random stimulus, every cycle
// compared against a behavioural model of the sequencing rules.
module tb_board_supervisor;
   localparam int TSW    = 4;
   localparam int SU     = 4;
   localparam int SD     = 3;
   localparam int LT     = 5;
   localparam int CW     = 8;
   localparam int TS_MAX = (1 << TSW) - 1;
`ifdef BOARD_SUPERVISOR_LINK_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   board_supervisor_if #(.TS_WIDTH(TSW)) bus ();

   board_supervisor #(
      .TS_WIDTH      (TSW),
      .STARTUP_TICKS (SU),
      .SHUTDOWN_TICKS(SD),
      .LINK_TIMEOUT  (LT),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [1:0]     st;
      logic           run;
      logic           men;
      logic [TSW-1:0] ts;
      logic           flt;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state (phase names: 0 idle, 1 startup, 2 running, 3 shutdown)
   int m_st = 0, m_cnt = 0, m_wd = 0, m_ts = 0;
   bit m_men = 0, m_flt = 0;
   bit m_bq = 1, m_bp = 1, m_mq = 1, m_mp = 1;

   bit d_rst = 1, d_btn = 1, d_mreq = 0, d_thr = 0, d_link = 0;

   function automatic void model_step(bit r, bit t, bit b, bit m, bit th, bit l);
      bit be, me, trip;
      if (r) begin
         m_st = 0; m_cnt = 0; m_wd = 0; m_ts = 0; m_men = 0; m_flt = 0;
         m_bq = 1; m_bp = 1; m_mq = 1; m_mp = 1;
         return;
      end
      be   = m_bq && !m_bp;
      me   = m_mq && !m_mp;
      trip = 0;
      case (m_st)
         0: if (be) begin m_st = 1; m_cnt = 0; m_flt = 0; end
         1: begin
            if (be) begin
               m_st = 3; m_cnt = 0;
            end else if (t) begin
               m_cnt++;
               if (m_cnt == SU) begin m_st = 2; m_cnt = 0; end
            end
         end
         2: begin
            if (WD_ON) begin
               if (l) m_wd = 0;
               else if (t) begin
                  m_wd++;
                  if (m_wd == LT) trip = 1;
               end
            end
            if (me) m_men = m_men ? 1'b0 : th;
            if (t && m_ts < TS_MAX) m_ts++;
            if (be || trip) begin
               m_st = 3; m_cnt = 0; m_men = 0; m_ts = 0; m_wd = 0;
               if (trip) m_flt = 1;
            end
         end
         default: begin
            if (t) begin
               m_cnt++;
               if (m_cnt == SD) begin m_st = 0; m_cnt = 0; end
            end
         end
      endcase
      m_bp = m_bq; m_bq = b;
      m_mp = m_mq; m_mq = m;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.st  = 2'(m_st);
      o.run = (m_st == 2);
      o.men = m_men;
      o.ts  = TSW'(m_ts);
      o.flt = m_flt;
      return o;
   endfunction

   task automatic step(input bit t);
      @(negedge clk);
      rst              = d_rst;
      bus.tick         = t;
      bus.btn          = d_btn;
      bus.motor_req    = d_mreq;
      bus.throttle_low = d_thr;
      bus.link_ok      = d_link;
      model_step(d_rst, t, d_btn, d_mreq, d_thr, d_link);
      exp_q.push_back(model_obs());
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         step(1'b1);
         step(1'b0);
         step(1'b0);
      end
   endtask

   task automatic pulse_btn();
      d_btn = 1; step(1'b0);
      d_btn = 0; step(1'b0);
   endtask

   task automatic pulse_mreq();
      d_mreq = 1; step(1'b0);
      d_mreq = 0; step(1'b0);
   endtask

   // Directed point check against a hand-derived constant, sampled just after the next edge.
   task automatic probe(input string name, input int got_sel, input int want);
      int got;
      @(posedge clk);
      #1;
      case (got_sel)
         0: got = int'(bus.board_state);
         1: got = int'(bus.motor_en);
         2: got = int'(bus.timestamp);
         3: got = int'(bus.fault);
         default: got = int'(bus.running);
      endcase
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end else begin
         $display("probe %s: %0d", name, got);
      end
   endtask

   // Scoreboard monitor: one expected observation per clock edge.
   initial begin
      obs_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {bus.board_state, bus.running, bus.motor_en, bus.timestamp, bus.fault};
            n_checks++;
            if (g !== e) begin
               n_errors++;
               $display("FAIL cycle_obs @%0t: got st=%0d run=%0b men=%0b ts=%0d flt=%0b expected st=%0d run=%0b men=%0b ts=%0d flt=%0b",
                        $time, g.st, g.run, g.men, g.ts, g.flt, e.st, e.run, e.men, e.ts, e.flt);
            end
         end
      end
   end

   initial begin
      bus.tick = 0; bus.btn = 1; bus.motor_req = 0; bus.throttle_low = 0; bus.link_ok = 0;

      // Reset held with button high, then released with button still high: no press.
      d_rst = 1; d_btn = 1; idle(2);
      probe("reset_idle", 0, 0);
      d_rst = 0; idle(2);
      probe("held_btn_no_edge", 0, 0);
      d_btn = 0; idle(1);
      pulse_btn();
      probe("startup_2clk", 0, 1);

      ticks(SU - 1);
      probe("startup_before_last_tick", 0, 1);
      ticks(1);
      probe("running_entry", 0, 2);
      probe("running_entry_ts", 2, 0);

      // Arming interlock
      d_thr = 0; pulse_mreq(); idle(2);
      probe("arm_blocked", 1, 0);
      d_thr = 1; pulse_mreq(); idle(2);
      probe("arm_ok", 1, 1);
      d_thr = 0; pulse_mreq(); idle(2);
      probe("disarm", 1, 0);

      // Timestamp saturation and shutdown
      ticks(20);
      probe("ts_saturated", 2, TS_MAX);
      d_thr = 1; pulse_mreq(); idle(2); d_thr = 0;
      probe("rearmed", 1, 1);
      pulse_btn();
      probe("shutdown_state", 0, 3);
      probe("shutdown_ts", 2, 0);
      probe("shutdown_motor", 1, 0);
      ticks(SD - 1);
      probe("shutdown_before_last", 0, 3);
      ticks(1);
      probe("back_to_idle", 0, 0);

      // Startup abort coincident with the completing tick
      pulse_btn(); idle(1);
      ticks(SU - 1);
      d_btn = 1; step(1'b0);
      d_btn = 0; step(1'b1);
      probe("abort_wins", 0, 3);
      idle(1); ticks(SD);
      probe("abort_to_idle", 0, 0);

      // Link watchdog
      pulse_btn(); ticks(SU);
      probe("wd_running", 0, 2);
      repeat (3) begin
         ticks(3);
         d_link = 1; step(1'b0); d_link = 0;
      end
      probe("wd_link_holds", 0, 2);
      ticks(LT);
`ifdef BOARD_SUPERVISOR_LINK_WATCHDOG_EN
      probe("wd_trip_state", 0, 3);
      probe("wd_trip_fault", 3, 1);
      ticks(SD);
      probe("wd_idle", 0, 0);
      probe("wd_fault_sticky", 3, 1);
      pulse_btn();
      probe("wd_fault_cleared", 3, 0);
      ticks(SU); pulse_btn(); ticks(SD);
`else
      probe("nowd_still_running", 0, 2);
      probe("nowd_fault", 3, 0);
      pulse_btn(); ticks(SD);
`endif

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         d_rst  = ($urandom_range(0, 799) == 0);
         d_btn  = ($urandom_range(0, 15) == 0);
         d_mreq = ($urandom_range(0, 7) == 0);
         d_thr  = ($urandom_range(0, 1) == 1);
         d_link = ($urandom_range(0, 11) == 0);
         step($urandom_range(0, 3) == 0);
      end
      d_rst = 0; d_btn = 0; d_mreq = 0; d_thr = 0; d_link = 0;
      idle(2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
